// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 scancode-set-2 receiver: frame FSM encoding,
// prefix bytes, the list of bytes that carry no key event, and default timing.
package ps2_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  localparam int DEF_FILTER_LEN = 8;
  localparam int DEF_TIMEOUT    = 65535;

  // Keyboard status/ack bytes that never describe a key.
  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA,
      8'hFC, 8'hFD, 8'hFE, 8'hFF: is_discard = 1'b1;
      default:                    is_discard = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pin conditioning: two-FF synchronisers, a run-length glitch filter on the
// clock line, and a one-cycle pulse on each filtered falling clock edge.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic fall,
  output logic dat
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          filt;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // in the block samples the values from before the clock edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt     <= 1'b1;
      cnt      <= '0;
      fall     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      fall     <= 1'b0;
      // The level flips only after FILTER_LEN back-to-back differing samples.
      if (clk_sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= clk_sync[1];
        cnt  <= '0;
        fall <= filt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign dat = dat_sync[1];

endmodule

// File: rtl/ps2_scancode.sv
// PS/2 keyboard receiver and scancode-set-2 decoder for the Spectrum key matrix.
// Define PS2_PAUSE_FILTER_EN to swallow the whole E1-led Pause key sequence.
module ps2_scancode
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       strobe,
  output logic       pressed,
  output logic [7:0] code,
  output logic       extended,
  output logic       error
);

  logic        fall;
  logic        dat;
  logic [1:0]  state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        par;
  logic [15:0] tcnt;
  logic        brk;
  logic        ext;
  logic        expired;
  logic        byte_valid;
  logic        fault;
  logic        skip_active;
  logic        swallow;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clock   (clock),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .fall    (fall),
    .dat     (dat)
  );

  always_comb begin
    expired    = (state != ST_IDLE) && (tcnt == 16'(TIMEOUT));
    byte_valid = fall && (state == ST_STOP) && dat && (^{shift, par});
    fault      = (fall && (state == ST_IDLE) && dat)
              || (fall && (state == ST_STOP) && !byte_valid)
              || (!fall && expired);
    swallow    = skip_active || is_discard(shift) || (shift == PS2_PAUSE);
  end

  // Frame FSM and inter-edge timeout; a fall in the expiry cycle wins.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par     <= 1'b0;
      tcnt    <= '0;
    end else if (fall) begin
      tcnt <= '0;
      case (state)
        ST_IDLE: if (!dat) begin
          state   <= ST_DATA;
          bit_cnt <= '0;
        end
        ST_DATA: begin
          shift   <= {dat, shift[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= ST_PARITY;
        end
        ST_PARITY: begin
          par   <= dat;
          state <= ST_STOP;
        end
        ST_STOP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end else if (state == ST_IDLE) begin
      tcnt <= '0;
    end else if (expired) begin
      state <= ST_IDLE;
      tcnt  <= '0;
    end else begin
      tcnt <= tcnt + 16'd1;
    end
  end

  // Prefix flags and the key-event outputs the matrix latches.
  always_ff @(posedge clock) begin
    if (!reset) begin
      strobe   <= 1'b0;
      error    <= 1'b0;
      code     <= 8'h00;
      pressed  <= 1'b1;
      extended <= 1'b0;
      brk      <= 1'b0;
      ext      <= 1'b0;
    end else begin
      strobe <= 1'b0;
      error  <= fault;
      if (fault) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (byte_valid && !swallow) begin
        if (shift == PS2_BREAK) begin
          brk <= 1'b1;
        end else if (shift == PS2_EXT) begin
          ext <= 1'b1;
        end else begin
          strobe   <= 1'b1;
          code     <= shift;
          pressed  <= brk;
          extended <= ext;
          brk      <= 1'b0;
          ext      <= 1'b0;
        end
      end
    end
  end

`ifdef PS2_PAUSE_FILTER_EN
  logic [2:0] skip;

  assign skip_active = (skip != 3'd0);

  // E1 starts the Pause sequence; the following seven bytes belong to it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      skip <= '0;
    end else if (fault) begin
      skip <= '0;
    end else if (byte_valid) begin
      if (skip_active)              skip <= skip - 3'd1;
      else if (shift == PS2_PAUSE)  skip <= 3'd7;
    end
  end
`else
  assign skip_active = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_scancode.sv
// Self-checking bench for ps2_scancode: table of single-frame vectors plus
// hand-written glitch, timeout, mid-frame reset and Pause sequences.
module tb_ps2_scancode;

  localparam int FL   = 4;
  localparam int TO   = 300;
  localparam int HALF = 12;

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    int         n_strobe;
    int         n_error;
    logic [7:0] code;
    logic       pressed;
    logic       ext;
  } vec_t;

  typedef struct {
    logic [7:0] code;
    logic       pressed;
    logic       ext;
  } ev_t;

  logic       clock;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       strobe;
  logic       pressed;
  logic [7:0] code;
  logic       extended;
  logic       error;

  int checks    = 0;
  int errors    = 0;
  int n_strobe  = 0;
  int n_error   = 0;
  int n_overlap = 0;
  int n_wide    = 0;
  logic prev_strobe = 1'b0;
  ev_t  evq[$];
  vec_t vecs[14];

  ps2_scancode #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .strobe   (strobe),
    .pressed  (pressed),
    .code     (code),
    .extended (extended),
    .error    (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (strobe) begin
      evq.push_back(ev_t'{code, pressed, extended});
      n_strobe++;
    end
    if (error) n_error++;
    if (strobe && error) n_overlap++;
    if (strobe && prev_strobe) n_wide++;
    prev_strobe = strobe;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Sends the first nbits of a frame; glitch_at injects a short clock pulse after that bit.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int glitch_at, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clock) ps2_dat = bits[i];
      repeat (HALF) @(negedge clock);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clock);
      ps2_clk = 1'b1;
      if (i == glitch_at) begin
        repeat (8) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (FL - 2) @(negedge clock);
        ps2_clk = 1'b1;
      end
    end
    repeat (HALF) @(negedge clock);
  endtask

  task automatic settle();
    repeat (30) @(posedge clock);
    #1;
  endtask

  task automatic check_key(input string name, input int s0, input int e0, input int ns,
                           input logic [7:0] c, input logic p, input logic x);
    check({name, " strobes"},  n_strobe - s0, ns);
    check({name, " errors"},   n_error - e0, 0);
    check({name, " code"},     code, c);
    check({name, " pressed"},  pressed, p);
    check({name, " extended"}, extended, x);
  endtask

  initial begin
    int s0, e0;

    vecs[0]  = '{8'h1C, 1'b0, 1, 0, 8'h1C, 1'b0, 1'b0};
    vecs[1]  = '{8'hF0, 1'b0, 0, 0, 8'h1C, 1'b0, 1'b0};
    vecs[2]  = '{8'h1C, 1'b0, 1, 0, 8'h1C, 1'b1, 1'b0};
    vecs[3]  = '{8'hE0, 1'b0, 0, 0, 8'h1C, 1'b1, 1'b0};
    vecs[4]  = '{8'hF0, 1'b0, 0, 0, 8'h1C, 1'b1, 1'b0};
    vecs[5]  = '{8'h75, 1'b0, 1, 0, 8'h75, 1'b1, 1'b1};
    vecs[6]  = '{8'h75, 1'b0, 1, 0, 8'h75, 1'b0, 1'b0};
    vecs[7]  = '{8'hF0, 1'b0, 0, 0, 8'h75, 1'b0, 1'b0};
    vecs[8]  = '{8'h1C, 1'b1, 0, 1, 8'h75, 1'b0, 1'b0};
    vecs[9]  = '{8'h1B, 1'b0, 1, 0, 8'h1B, 1'b0, 1'b0};
    vecs[10] = '{8'hAA, 1'b0, 0, 0, 8'h1B, 1'b0, 1'b0};
    vecs[11] = '{8'hE0, 1'b0, 0, 0, 8'h1B, 1'b0, 1'b0};
    vecs[12] = '{8'hFA, 1'b0, 0, 0, 8'h1B, 1'b0, 1'b0};
    vecs[13] = '{8'h6B, 1'b0, 1, 0, 8'h6B, 1'b0, 1'b1};

    reset   = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("reset strobe",   strobe, 0);
    check("reset error",    error, 0);
    check("reset code",     code, 8'h00);
    check("reset pressed",  pressed, 1);
    check("reset extended", extended, 0);
    @(negedge clock) reset = 1'b1;
    repeat (5) @(negedge clock);

    for (int i = 0; i < 14; i++) begin
      s0 = n_strobe;
      e0 = n_error;
      send_frame(vecs[i].data, vecs[i].bad_par, -1, 11);
      settle();
      check($sformatf("vec%0d strobes", i),  n_strobe - s0, vecs[i].n_strobe);
      check($sformatf("vec%0d errors", i),   n_error - e0, vecs[i].n_error);
      check($sformatf("vec%0d code", i),     code, vecs[i].code);
      check($sformatf("vec%0d pressed", i),  pressed, vecs[i].pressed);
      check($sformatf("vec%0d extended", i), extended, vecs[i].ext);
    end

    // Short clock glitch while idle with data high would otherwise flag an error.
    s0 = n_strobe; e0 = n_error;
    @(negedge clock) ps2_clk = 1'b0;
    repeat (FL - 2) @(negedge clock);
    ps2_clk = 1'b1;
    settle();
    check("idle glitch strobes", n_strobe - s0, 0);
    check("idle glitch errors",  n_error - e0, 0);

    s0 = n_strobe; e0 = n_error;
    send_frame(8'h4B, 1'b0, 4, 11);
    settle();
    check_key("frame glitch", s0, e0, 1, 8'h4B, 1'b0, 1'b0);

    // Partial frame then silence: exactly one timeout error.
    s0 = n_strobe; e0 = n_error;
    send_frame(8'h55, 1'b0, -1, 5);
    repeat (TO + 40) @(posedge clock);
    #1;
    check("timeout errors",  n_error - e0, 1);
    check("timeout strobes", n_strobe - s0, 0);
    s0 = n_strobe; e0 = n_error;
    send_frame(8'h29, 1'b0, -1, 11);
    settle();
    check_key("after timeout", s0, e0, 1, 8'h29, 1'b0, 1'b0);

    // Reset in the middle of a frame.
    s0 = n_strobe; e0 = n_error;
    send_frame(8'h33, 1'b0, -1, 4);
    @(negedge clock) reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("midreset code",     code, 8'h00);
    check("midreset pressed",  pressed, 1);
    check("midreset extended", extended, 0);
    @(negedge clock) reset = 1'b1;
    settle();
    check("midreset strobes", n_strobe - s0, 0);
    check("midreset errors",  n_error - e0, 0);
    s0 = n_strobe; e0 = n_error;
    send_frame(8'h5A, 1'b0, -1, 11);
    settle();
    check_key("after midreset", s0, e0, 1, 8'h5A, 1'b0, 1'b0);

    // Pause key: E1 14 77 E1 F0 14 F0 77.
    evq.delete();
    s0 = n_strobe; e0 = n_error;
    send_frame(8'hE1, 1'b0, -1, 11);
    send_frame(8'h14, 1'b0, -1, 11);
    send_frame(8'h77, 1'b0, -1, 11);
    send_frame(8'hE1, 1'b0, -1, 11);
    send_frame(8'hF0, 1'b0, -1, 11);
    send_frame(8'h14, 1'b0, -1, 11);
    send_frame(8'hF0, 1'b0, -1, 11);
    send_frame(8'h77, 1'b0, -1, 11);
    settle();
    check("pause errors", n_error - e0, 0);
`ifdef PS2_PAUSE_FILTER_EN
    check("pause strobes", n_strobe - s0, 0);
`else
    check("pause strobes", n_strobe - s0, 4);
    if (evq.size() == 4) begin
      check("pause ev0 code", evq[0].code, 8'h14);
      check("pause ev0 pressed", evq[0].pressed, 0);
      check("pause ev1 code", evq[1].code, 8'h77);
      check("pause ev1 pressed", evq[1].pressed, 0);
      check("pause ev2 code", evq[2].code, 8'h14);
      check("pause ev2 pressed", evq[2].pressed, 1);
      check("pause ev3 code", evq[3].code, 8'h77);
      check("pause ev3 pressed", evq[3].pressed, 1);
      check("pause ev3 extended", evq[3].ext, 0);
    end
`endif
    s0 = n_strobe; e0 = n_error;
    send_frame(8'h1C, 1'b0, -1, 11);
    settle();
    check_key("after pause", s0, e0, 1, 8'h1C, 1'b0, 1'b0);

    check("strobe/error overlap", n_overlap, 0);
    check("strobe width", n_wide, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_scancode.md
# ps2_scancode

PS/2 keyboard receiver and scancode-set-2 decoder feeding the Spectrum key matrix. It synchronises and filters the raw PS/2 clock and data lines, assembles 11-bit frames, and strips the F0 (break) and E0 (extended) prefixes. It emits one single-cycle `strobe` per key event, carrying `code` and an active-low `pressed` level, so the matrix can latch `pressed` directly into its key bits.

## Interface
Parameters:
- `FILTER_LEN`, default 8: consecutive equal samples needed before the filtered PS/2 clock changes level.
- `TIMEOUT`, default 65535: `clock` cycles without a falling edge before a partial frame is aborted; counter is 16 bits.

Ports:
- `clock` in, 1: system clock; the only clock domain.
- `reset` in, 1: synchronous, active-low reset.
- `ps2_clk` in, 1: raw PS/2 clock pin (asynchronous).
- `ps2_dat` in, 1: raw PS/2 data pin (asynchronous).
- `strobe` out, 1: one-cycle pulse, key event valid.
- `pressed` out, 1: 0 = make, 1 = break; held until next strobe.
- `code` out, 8: scancode without prefixes; held until next strobe.
- `extended` out, 1: event was E0-prefixed; held until next strobe.
- `error` out, 1: one-cycle pulse on a framing, parity or timeout fault.

## Operation
- Input conditioning:
  - Two-FF synchroniser on each pin.
  - Clock filter: a counter runs while the synchronised clock differs from the filtered level. It reloads when the two match. After `FILTER_LEN` consecutive differing samples, the filtered level flips.
  - A filtered 1→0 transition creates a one-cycle `fall` event. Data is sampled on `fall`.
- Frame FSM, all transitions on `fall` only:
  - IDLE: data 0 → DATA with bit count 0. Data 1 → `error`, stay in IDLE.
  - DATA: shift data in LSB first. After bit 7 → PARITY.
  - PARITY: store the bit. → STOP.
  - STOP: data 1 and odd parity over data+parity → byte valid. Otherwise → `error`. Either way → IDLE.
- Timeout counter:
  - Clears on every `fall` and while in IDLE.
  - Reaching `TIMEOUT` outside IDLE → `error` pulse and return to IDLE.
- Byte handling for a valid byte:
  - F0: set `brk`. No strobe.
  - E0: set `ext`. No strobe.
  - E1: see Configuration.
  - 00, AA, EE, FA, FC, FD, FE, FF: discard. Flags unchanged. No strobe.
  - Any other byte: strobe. `code` = byte, `pressed` = `brk`, `extended` = `ext`. Then clear `brk` and `ext`.
- Any error clears `brk`, `ext` and the pause skip counter.

## Timing
- Reset values: `strobe` 0, `error` 0, `code` 8'h00, `pressed` 1, `extended` 0.
- Reset also sets FSM to IDLE, clears `brk`/`ext`/skip counter/timeout, and sets the filtered clock to 1.
- Reset mid-frame discards the partial frame. No strobe and no error is produced.
- Pin-to-`fall` latency: 2 sync cycles + `FILTER_LEN` cycles + 1 cycle.
- If the stop bit is sampled on the `fall` of cycle N, then `strobe`/`error` and the updated `code`/`pressed`/`extended` appear in cycle N+1. Strobe lasts exactly one cycle.
- `strobe` and `error` are never asserted in the same cycle.
- If timeout expiry and `fall` land in the same cycle, `fall` wins and the counter clears.
- Bit count wraps only through the IDLE state. A frame never exceeds 11 falls.

## Configuration
- `PS2_PAUSE_FILTER_EN` defined:
  - Byte E1 loads a skip counter with 7.
  - The next 7 valid bytes are consumed with no strobe and no flag change. This covers the whole Pause sequence (E1 14 77 E1 F0 14 F0 77).
- Undefined: E1 is discarded like 00/AA/… and the following bytes decode normally, so the Pause key yields spurious 14/77 events.

## Structure
- Shared package `ps2_pkg`:
  - FSM state encoding (IDLE, DATA, PARITY, STOP).
  - Byte constants: `PS2_BREAK`=8'hF0, `PS2_EXT`=8'hE0, `PS2_PAUSE`=8'hE1.
  - Discard list.
  - Default `FILTER_LEN`/`TIMEOUT`.
- Sub-module `ps2_line_filter`: synchroniser + clock glitch filter + `fall` generator. Outputs are `fall` and synchronised data.
- Top level holds the FSM, shifter, timeout, prefix flags and output registers.

## Test plan
- Make: frame 0x1C (parity 0, stop 1) → one strobe, `code`=1C, `pressed`=0, `extended`=0.
- Break: F0 then 1C → exactly one strobe, `code`=1C, `pressed`=1. No strobe for F0.
- Extended: E0 F0 75 → strobe `code`=75, `pressed`=1, `extended`=1. A following plain 75 → `pressed`=0, `extended`=0.
- Parity fault: 0x1C with parity 1 → `error` pulse, no strobe. Next good 0x1B → strobe `code`=1B with `pressed`=0 (`brk` cleared).
- Timeout and glitch:
  - 5 bits, then idle for `TIMEOUT`+10 cycles → one `error`. Next frame 0x29 decodes correctly.
  - A `ps2_clk` low pulse of `FILTER_LEN`−2 cycles → no bit sampled.
- Pause: full Pause sequence with `PS2_PAUSE_FILTER_EN` → zero strobes. Without the macro → strobes for 14, 77, then 14 and 77 with `pressed`=1.
